rptr_handler_lvl: RTL and testbench

Parametrised read-side pointer/flag generator for the async FIFO between the packer and the AXI/DDR write path. It supersedes the basic read-pointer handler by adding:
- a registered fill level
- a programmable almost-empty flag
- a read-data-valid strobe aligned to the FIFO memory's registered read port
- a sticky underflow error flag
It runs entirely in the read clock domain and consumes the write pointer after it has been Gray-coded and synchronised.

---
 rtl/fifo_pkg.sv | 24 ++
 rtl/rptr_handler_lvl_if.sv | 31 +++
 rtl/rptr_handler_lvl.sv | 81 ++++++++
 tb/tb_rptr_handler_lvl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Gray/binary pointer helpers shared by the read- and write-side
// FIFO pointer handlers.
package fifo_pkg;

   localparam int PTR_MAX_W = 32;

   // Wide carrier word; callers zero-extend in and size-cast out.
   typedef logic [PTR_MAX_W-1:0] ptr_word_t;

   function automatic ptr_word_t bin2gray(input ptr_word_t b);
      return b ^ (b >> 1);
   endfunction

   // Upper bits are zero, so the prefix XOR is exact for any width.
   function automatic ptr_word_t gray2bin(input ptr_word_t g);
      ptr_word_t b;
      b = '0;
      for (int i = 0; i < PTR_MAX_W; i++) begin
         b[i] = ^(g >> i);
      end
      return b;
   endfunction

endpackage

// File: rtl/rptr_handler_lvl_if.sv
// Read-side FIFO pointer bundle: requests and synced write pointer in,
// registered pointers, level and flags out.
interface rptr_handler_lvl_if #(
   parameter int PTR_WIDTH = 3
);

   logic                 r_en;
   logic                 clr_err;
   logic [PTR_WIDTH:0]   g_wptr_sync;
   logic [PTR_WIDTH:0]   b_rptr;
   logic [PTR_WIDTH:0]   g_rptr;
   logic [PTR_WIDTH-1:0] raddr;
   logic                 empty;
   logic                 almost_empty;
   logic [PTR_WIDTH:0]   rd_level;
   logic                 rd_valid;
   logic                 underflow;

   modport master (
      output r_en, clr_err, g_wptr_sync,
      input  b_rptr, g_rptr, raddr, empty, almost_empty,
      input  rd_level, rd_valid, underflow
   );

   modport slave (
      input  r_en, clr_err, g_wptr_sync,
      output b_rptr, g_rptr, raddr, empty, almost_empty,
      output rd_level, rd_valid, underflow
   );

endinterface

// File: rtl/rptr_handler_lvl.sv
// Read-domain FIFO pointer handler with registered fill level,
// almost-empty, read-valid strobe and sticky underflow.
module rptr_handler_lvl
   import fifo_pkg::*;
#(
   parameter int PTR_WIDTH     = 3,
   parameter int AEMPTY_THRESH = 2
) (
   input  logic            rclk,
   input  logic            rrst,
   rptr_handler_lvl_if.slave bus
);

   localparam int PW    = PTR_WIDTH + 1;
   localparam int DEPTH = 1 << PTR_WIDTH;
   localparam logic [PW-1:0] AE_TH = PW'(AEMPTY_THRESH);

   if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > DEPTH - 1) begin : g_bad_thresh
      $error("AEMPTY_THRESH out of range 0..DEPTH-1");
   end

   logic [PW-1:0] b_q, b_d;
   logic [PW-1:0] g_q, g_d;
   logic [PW-1:0] lvl_q, lvl_d;
   logic [PW-1:0] w_bin;
   logic          empty_q, empty_d;
   logic          aempty_q, aempty_d;
   logic          valid_q, valid_d;
   logic          uflow_q, uflow_d;
   logic          rd_accept;

   assign w_bin = PW'(gray2bin(ptr_word_t'(bus.g_wptr_sync)));

   // Accept only against the registered empty: never on a stale flag.
   assign rd_accept = bus.r_en & ~empty_q;

   always_comb begin
      b_d      = b_q + PW'(rd_accept);
      g_d      = PW'(bin2gray(ptr_word_t'(b_d)));
      lvl_d    = w_bin - b_d;
      empty_d  = (bus.g_wptr_sync == g_d);
      aempty_d = (lvl_d <= AE_TH);
      valid_d  = rd_accept;
      uflow_d  = uflow_q;
      if (bus.r_en && empty_q) begin
         uflow_d = 1'b1;
      end else if (bus.clr_err) begin
         uflow_d = 1'b0;
      end
   end

   always_ff @(posedge rclk or negedge rrst) begin
      if (!rrst) begin
         b_q      <= '0;
         g_q      <= '0;
         lvl_q    <= '0;
         empty_q  <= 1'b1;
         aempty_q <= 1'b1;
         valid_q  <= 1'b0;
         uflow_q  <= 1'b0;
      end else begin
         b_q      <= b_d;
         g_q      <= g_d;
         lvl_q    <= lvl_d;
         empty_q  <= empty_d;
         aempty_q <= aempty_d;
         valid_q  <= valid_d;
         uflow_q  <= uflow_d;
      end
   end

   assign bus.b_rptr       = b_q;
   assign bus.g_rptr       = g_q;
   assign bus.raddr        = b_q[PTR_WIDTH-1:0];
   assign bus.empty        = empty_q;
   assign bus.almost_empty = aempty_q;
   assign bus.rd_level     = lvl_q;
   assign bus.rd_valid     = valid_q;
   assign bus.underflow    = uflow_q;

endmodule

// File: tb/tb_rptr_handler_lvl.sv
// Scoreboard bench for rptr_handler_lvl: an integer reference model
// pushes expected registered outputs, popped after each rclk edge.
module tb_rptr_handler_lvl;

   localparam int PTR_WIDTH = 3;
   localparam int AE_TH     = 2;

   logic rclk;
   logic rrst;

   rptr_handler_lvl_if #(.PTR_WIDTH(PTR_WIDTH)) bus ();

   rptr_handler_lvl #(
      .PTR_WIDTH    (PTR_WIDTH),
      .AEMPTY_THRESH(AE_TH)
   ) dut (
      .rclk(rclk),
      .rrst(rrst),
      .bus (bus)
   );

   initial rclk = 1'b0;
   always #5 rclk = ~rclk;

   typedef struct {
      int b;
      int g;
      int ra;
      int e;
      int ae;
      int lvl;
      int v;
      int uf;
   } exp_t;

   exp_t exp_q[$];

   int n_cmp;
   int n_err;

   // Reference model state (integers, mod 16 pointers).
   int m_b;
   int m_empty;
   int m_uf;
   int vcount;

   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d want %0d", tag, obs, exp);
      end
   endtask

   function automatic int gray4(input int v);
      return (v ^ (v >> 1)) & 15;
   endfunction

   task automatic model_reset();
      m_b     = 0;
      m_empty = 1;
      m_uf    = 0;
      exp_q.delete();
   endtask

   task automatic check_reset(input string tag);
      chk({tag, ".b"},   int'(bus.b_rptr), 0);
      chk({tag, ".g"},   int'(bus.g_rptr), 0);
      chk({tag, ".e"},   int'(bus.empty), 1);
      chk({tag, ".ae"},  int'(bus.almost_empty), 1);
      chk({tag, ".lvl"}, int'(bus.rd_level), 0);
      chk({tag, ".v"},   int'(bus.rd_valid), 0);
      chk({tag, ".uf"},  int'(bus.underflow), 0);
   endtask

   // One rclk cycle: drive, predict, wait an edge, pop and compare.
   task automatic cyc(input int ren, input int clr, input int wbin);
      exp_t x;
      int   acc;
      int   lvl;
      bus.r_en        = ren[0];
      bus.clr_err     = clr[0];
      bus.g_wptr_sync = 4'(gray4(wbin));
      acc   = ren & (m_empty == 0 ? 1 : 0);
      m_uf  = (ren != 0 && m_empty != 0) ? 1 : (clr != 0 ? 0 : m_uf);
      m_b   = (m_b + acc) & 15;
      lvl   = (wbin - m_b) & 15;
      m_empty = (lvl == 0) ? 1 : 0;
      x.b   = m_b;
      x.g   = gray4(m_b);
      x.ra  = m_b & 7;
      x.e   = m_empty;
      x.ae  = (lvl <= AE_TH) ? 1 : 0;
      x.lvl = lvl;
      x.v   = acc;
      x.uf  = m_uf;
      exp_q.push_back(x);
      @(posedge rclk);
      #1;
      if (exp_q.size() == 0) begin
         chk("queue_empty", 1, 0);
      end else begin
         x = exp_q.pop_front();
         chk("b_rptr",       int'(bus.b_rptr),       x.b);
         chk("g_rptr",       int'(bus.g_rptr),       x.g);
         chk("raddr",        int'(bus.raddr),        x.ra);
         chk("empty",        int'(bus.empty),        x.e);
         chk("almost_empty", int'(bus.almost_empty), x.ae);
         chk("rd_level",     int'(bus.rd_level),     x.lvl);
         chk("rd_valid",     int'(bus.rd_valid),     x.v);
         chk("underflow",    int'(bus.underflow),    x.uf);
         chk("inv_empty_lvl", int'(bus.empty),
             (bus.rd_level == 0) ? 1 : 0);
      end
      vcount += int'(bus.rd_valid);
   endtask

   initial begin
      n_cmp  = 0;
      n_err  = 0;
      vcount = 0;
      rrst   = 1'b0;
      bus.r_en        = 1'b0;
      bus.clr_err     = 1'b0;
      bus.g_wptr_sync = '0;
      model_reset();
      repeat (2) @(posedge rclk);
      #1;
      check_reset("por");
      #2 rrst = 1'b1;

      // Fill visibility
      cyc(0, 0, 5);
      chk("fill.lvl", int'(bus.rd_level), 5);
      chk("fill.ae",  int'(bus.almost_empty), 0);

      // Drain five words
      vcount = 0;
      for (int i = 0; i < 5; i++) begin
         cyc(1, 0, 5);
         chk("drain.lvl", int'(bus.rd_level), 4 - i);
         chk("drain.ae",  int'(bus.almost_empty), (4 - i) <= 2 ? 1 : 0);
      end
      chk("drain.vcnt", vcount, 5);
      chk("drain.b", int'(bus.b_rptr), 5);
      chk("drain.g", int'(bus.g_rptr), 7);
      chk("drain.e", int'(bus.empty), 1);

      // Underflow: set, hold, set-beats-clear, lone clear
      cyc(1, 0, 5);
      chk("uf.set", int'(bus.underflow), 1);
      chk("uf.b",   int'(bus.b_rptr), 5);
      chk("uf.v",   int'(bus.rd_valid), 0);
      cyc(0, 0, 5);
      chk("uf.hold", int'(bus.underflow), 1);
      cyc(1, 1, 5);
      chk("uf.setwins", int'(bus.underflow), 1);
      cyc(0, 1, 5);
      chk("uf.clr", int'(bus.underflow), 0);
      cyc(0, 0, 5);

      // Mid-run asynchronous reset, checked before any edge
      #2 rrst = 1'b0;
      #1;
      check_reset("midrst");
      model_reset();
      bus.g_wptr_sync = '0;
      @(posedge rclk);
      #3 rrst = 1'b1;

      // Full, then wrap through the pointer MSB
      cyc(0, 0, 8);
      chk("full.lvl", int'(bus.rd_level), 8);
      for (int i = 0; i < 8; i++) cyc(1, 0, 8);
      chk("full.b", int'(bus.b_rptr), 8);
      chk("full.g", int'(bus.g_rptr), 12);
      chk("full.e", int'(bus.empty), 1);
      cyc(0, 0, 11);
      chk("w11.lvl", int'(bus.rd_level), 3);
      for (int i = 0; i < 3; i++) cyc(1, 0, 11);
      cyc(0, 0, 2);
      chk("w2.lvl", int'(bus.rd_level), 7);
      for (int i = 0; i < 7; i++) cyc(1, 0, 2);
      chk("wrap.b",  int'(bus.b_rptr), 2);
      chk("wrap.ra", int'(bus.raddr), 2);
      chk("wrap.e",  int'(bus.empty), 1);

      // Simultaneous read and write-pointer advance at level 3
      cyc(0, 0, 5);
      chk("sim.pre", int'(bus.rd_level), 3);
      cyc(1, 0, 6);
      chk("sim.lvl", int'(bus.rd_level), 3);
      chk("sim.v",   int'(bus.rd_valid), 1);

      // Randomised tail against the model
      for (int i = 0; i < 60; i++) begin
         int w;
         w = (m_b + int'($urandom_range(0, 8))) & 15;
         cyc(int'($urandom_range(0, 1)), int'($urandom_range(0, 3) == 0), w);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
